// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: SRAM controller state encoding and default mapping constants.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   localparam int DATA_MEM_BASE     = 1024;
   localparam int SRAM_WAIT_DEFAULT = 1;

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one 16-bit SRAM half; tc flags the last cycle of the phase.
module sram_phase_counter
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   output logic [2:0] cnt,
   output logic       tc
);

   assign tc = (cnt == 3'(WAIT_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 3'd0;
      end else if (clear) begin
         cnt <= 3'd0;
      end else if (enable) begin
         cnt <= cnt + 3'd1;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// Memory-stage controller: splits a 32-bit load/store into two 16-bit SRAM accesses, low half first.
module sram_controller
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT,
   parameter int BASE_ADDR   = DATA_MEM_BASE,
   parameter int SRAM_AW     = 18,
   parameter int SRAM_DW     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   sram_state_t        state_reg;
   logic [SRAM_AW-2:0] word_reg;
   logic [15:0]        wdata_hi_reg;
   logic               op_wr_reg;

   logic               req;
   logic [31:0]        off;
   logic               busy;
   logic               tc;
   logic [2:0]         cnt;
   logic               unused_off_bits;

   assign req  = rd_en | wr_en;
   assign off  = address - 32'(BASE_ADDR);
   assign busy = (state_reg == LO) || (state_reg == HI);

   // Byte offset bits and bits above the SRAM span are dropped without a range check.
   assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0], cnt};

   assign ready = ((state_reg == IDLE) && !req) || (state_reg == DONE);

   sram_phase_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_phase_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (!busy || tc),
      .enable (busy),
      .cnt    (cnt),
      .tc     (tc)
   );

   // SRAM pins are registered and loaded on the transition into each phase,
   // so they are stable for every cycle the phase lasts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         word_reg     <= '0;
         wdata_hi_reg <= '0;
         op_wr_reg    <= 1'b0;
         read_data    <= '0;
         sram_addr    <= '0;
         sram_dq_out  <= '0;
         sram_dq_oe   <= 1'b0;
         sram_we_n    <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  state_reg    <= LO;
                  word_reg     <= off[SRAM_AW:2];
                  wdata_hi_reg <= write_data[31:16];
                  op_wr_reg    <= wr_en;
                  sram_addr    <= {off[SRAM_AW:2], 1'b0};
                  sram_dq_out  <= wr_en ? write_data[15:0] : '0;
                  sram_dq_oe   <= wr_en;
                  sram_we_n    <= !wr_en;
               end
            end
            LO: begin
               if (tc) begin
                  state_reg   <= HI;
                  sram_addr   <= {word_reg, 1'b1};
                  sram_dq_out <= op_wr_reg ? wdata_hi_reg : '0;
                  if (!op_wr_reg) begin
                     read_data[15:0] <= sram_dq_in;
                  end
               end
            end
            HI: begin
               if (tc) begin
                  state_reg   <= DONE;
                  sram_addr   <= '0;
                  sram_dq_out <= '0;
                  sram_dq_oe  <= 1'b0;
                  sram_we_n   <= 1'b1;
                  if (!op_wr_reg) begin
                     read_data[31:16] <= sram_dq_in;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: W=1 controller for the main sequence, W=0 controller for the short-latency load.
module tb_sram_controller;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst1 = 1'b0;
   logic        rst0 = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic        sel = 1'b0;

   logic [31:0] read_data1, read_data0;
   logic        ready1, ready0;
   logic [17:0] addr1, addr0;
   logic [15:0] dq_out1, dq_out0, dq_in1, dq_in0;
   logic        oe1, oe0, we_n1, we_n0;

   logic [15:0] mem1 [0:(1<<18)-1];
   logic [15:0] mem0 [0:(1<<18)-1];

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data1), .ready(ready1),
      .sram_addr(addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
      .sram_dq_oe(oe1), .sram_we_n(we_n1)
   );

   sram_controller #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst0), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data0), .ready(ready0),
      .sram_addr(addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
      .sram_dq_oe(oe0), .sram_we_n(we_n0)
   );

   // Behavioural SRAMs: combinational read, write while we_n is low at a clock edge.
   assign dq_in1 = mem1[addr1];
   assign dq_in0 = mem0[addr0];
   always @(posedge clk) if (!we_n1) mem1[addr1] <= dq_out1;
   always @(posedge clk) if (!we_n0) mem0[addr0] <= dq_out0;

   logic        m_ready, m_we_n, m_oe;
   logic [17:0] m_addr;
   logic [31:0] m_rdata;
   assign m_ready = sel ? ready0 : ready1;
   assign m_we_n  = sel ? we_n0 : we_n1;
   assign m_oe    = sel ? oe0 : oe1;
   assign m_addr  = sel ? addr0 : addr1;
   assign m_rdata = sel ? read_data0 : read_data1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Drives one request from a post-edge point and watches it until ready rises (bounded).
   task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         output int low, output logic [17:0] lo_addr, output logic [17:0] hi_addr,
                         output int we_cnt, output int oe_cnt, output logic first_ready);
      wr_en = w; rd_en = r; address = a; write_data = d;
      low = 0; we_cnt = 0; oe_cnt = 0; lo_addr = '1; hi_addr = '1; first_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) first_ready = m_ready;
         if (m_ready) break;
         if (low == 1) lo_addr = m_addr;
         hi_addr = m_addr;
         if (!m_we_n) we_cnt++;
         if (m_oe) oe_cnt++;
         low++;
      end
      $display("access wr=%0b rd=%0b addr=%0d wdata=0x%08h low=%0d sram_addr=%0d/%0d rdata=0x%08h",
               w, r, a, d, low, lo_addr, hi_addr, m_rdata);
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      next_edge();
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
   endtask

   int          low, we_cnt, oe_cnt;
   logic [17:0] lo_a, hi_a;
   logic        fr;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst1 = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(ready1), 32'd1);
      chk("idle_we_n", 32'(we_n1), 32'd1);
      chk("idle_rdata", read_data1, 32'd0);

      // Store 0x12345678 at 1024
      next_edge();
      access(1'b1, 1'b0, 32'd1024, 32'h12345678, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("st1_low", 32'(low), 32'd5);
      chk("st1_lo_addr", 32'(lo_a), 32'd0);
      chk("st1_hi_addr", 32'(hi_a), 32'd1);
      chk("st1_we_cycles", 32'(we_cnt), 32'd4);
      chk("st1_oe_cycles", 32'(oe_cnt), 32'd4);
      chk("st1_mem0", 32'(mem1[0]), 32'h5678);
      chk("st1_mem1", 32'(mem1[1]), 32'h1234);
      go_idle();

      // Load it back
      next_edge();
      access(1'b0, 1'b1, 32'd1024, 32'h0, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("ld1_low", 32'(low), 32'd5);
      chk("ld1_lo_addr", 32'(lo_a), 32'd0);
      chk("ld1_hi_addr", 32'(hi_a), 32'd1);
      chk("ld1_we_cycles", 32'(we_cnt), 32'd0);
      chk("ld1_oe_cycles", 32'(oe_cnt), 32'd0);
      chk("ld1_rdata_done", read_data1, 32'h12345678);
      go_idle();
      @(negedge clk);
      chk("ld1_rdata_hold", read_data1, 32'h12345678);

      // Store then load at 1028 with no idle gap
      next_edge();
      access(1'b1, 1'b0, 32'd1028, 32'hCAFEBABE, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("st2_low", 32'(low), 32'd5);
      chk("st2_lo_addr", 32'(lo_a), 32'd2);
      chk("st2_hi_addr", 32'(hi_a), 32'd3);
      next_edge();
      access(1'b0, 1'b1, 32'd1028, 32'h0, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("b2b_first_ready", 32'(fr), 32'd0);
      chk("ld2_low", 32'(low), 32'd5);
      chk("ld2_lo_addr", 32'(lo_a), 32'd2);
      chk("ld2_hi_addr", 32'(hi_a), 32'd3);
      chk("ld2_rdata", read_data1, 32'hCAFEBABE);
      go_idle();

      // Both enables: write wins, read_data untouched
      next_edge();
      access(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("both_low", 32'(low), 32'd5);
      chk("both_we_cycles", 32'(we_cnt), 32'd4);
      chk("both_mem4", 32'(mem1[4]), 32'hA5A5);
      chk("both_mem5", 32'(mem1[5]), 32'hA5A5);
      chk("both_rdata", read_data1, 32'hCAFEBABE);
      go_idle();

      // Reset during HI of a load
      next_edge();
      wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024;
      repeat (4) @(negedge clk);
      chk("rst_pre_hi_addr", 32'(addr1), 32'd1);
      rst1 = 1'b0;
      #1;
      chk("rst_state", 32'(dut1.state_reg), 32'(IDLE));
      chk("rst_rdata", read_data1, 32'd0);
      chk("rst_oe", 32'(oe1), 32'd0);
      chk("rst_we_n", 32'(we_n1), 32'd1);
      chk("rst_ready_req", 32'(ready1), 32'd0);
      rd_en = 1'b0;
      #1;
      chk("rst_ready_noreq", 32'(ready1), 32'd1);
      #1;
      rst1 = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(ready1), 32'd1);
      chk("post_rst_rdata", read_data1, 32'd0);

      // Zero-wait-state controller
      rst1 = 1'b0;
      sel = 1'b1;
      rst0 = 1'b1;
      @(negedge clk);
      next_edge();
      access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("w0_st_low", 32'(low), 32'd3);
      chk("w0_st_we_cycles", 32'(we_cnt), 32'd2);
      chk("w0_mem0", 32'(mem0[0]), 32'hBEEF);
      chk("w0_mem1", 32'(mem0[1]), 32'hDEAD);
      go_idle();
      next_edge();
      access(1'b0, 1'b1, 32'd1024, 32'h0, low, lo_a, hi_a, we_cnt, oe_cnt, fr);
      chk("w0_ld_low", 32'(low), 32'd3);
      chk("w0_ld_lo_addr", 32'(lo_a), 32'd0);
      chk("w0_ld_hi_addr", 32'(hi_a), 32'd1);
      chk("w0_ld_rdata", read_data0, 32'hDEADBEEF);
      go_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
